// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next fetch PC select: hold, sequential step or redirect.
// Build option FETCH_CTRL_ALIGN_CHECK_EN rejects misaligned redirects.
module fetch_pc_next
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            advance_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] target;

    always_comb begin
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        target     = redirect_pc_i;
        redirect_o = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);
        misalign_o = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
        target     = redirect_pc_i & ~32'h0000_0003;
        redirect_o = redirect_valid_i;
        misalign_o = 1'b0;
`endif
        if (redirect_o) begin
            pc_next_o = target;
        end else if (advance_i) begin
            pc_next_o = pc_i + PC_STEP;
        end else begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch FSM: one outstanding imem request, redirect kill, decode handshake.
// Build option FETCH_CTRL_ALIGN_CHECK_EN enables misaligned-redirect rejection.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_added,
    output logic            fetch_misalign
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic            kill_q;
    logic            req_q;
    logic            valid_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_added_q;
    logic            misalign_q;
    logic            advance;
    logic            redir;
    logic            misalign;

    assign advance = (state_q == HOLD) && if_ready;

    fetch_pc_next u_pc_next (
        .pc_i            (fetch_pc_q),
        .advance_i       (advance),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .pc_next_o       (fetch_pc_d),
        .redirect_o      (redir),
        .misalign_o      (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            inst_q     <= INST_NOP;
            pc_q       <= RESET_PC;
            pc_added_q <= RESET_PC + PC_STEP;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign;
            unique case (state_q)
                BOOT: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    // a granted request still returns data; kill it if redirected
                    if (imem_gnt) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                        kill_q  <= redir;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q || redir) begin
                            kill_q  <= 1'b0;
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            inst_q     <= imem_rdata;
                            pc_q       <= fetch_pc_q;
                            pc_added_q <= fetch_pc_q + PC_STEP;
                            valid_q    <= 1'b1;
                            state_q    <= HOLD;
                        end
                    end else if (redir) begin
                        kill_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (if_ready || redir) begin
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = fetch_pc_q;
    assign if_valid       = valid_q;
    assign if_inst        = inst_q;
    assign if_pc          = pc_q;
    assign if_pc_added    = pc_added_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl with RESET_PC = 0x100.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_added;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_pc_added   (if_pc_added),
        .fetch_misalign(fetch_misalign)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvld;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_ADDR = 32'h204;
    localparam logic        MIS_FLAG = 1'b1;
`else
    localparam logic [31:0] MIS_ADDR = 32'h300;
    localparam logic        MIS_FLAG = 1'b0;
`endif

    function automatic vec_t mk(
        logic rv, logic [31:0] rpc, logic gnt, logic rvld,
        logic [31:0] rdata, logic rdy, logic e_req, logic [31:0] e_addr,
        logic e_valid, logic [31:0] e_inst, logic [31:0] e_pc, logic e_mis);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvld = rvld;
        v.rdata = rdata; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc;
        v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b0;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, ".req"}, 32'(imem_req), 32'h0);
        chk({tag, ".addr"}, imem_addr, 32'h100);
        chk({tag, ".valid"}, 32'(if_valid), 32'h0);
        chk({tag, ".inst"}, if_inst, 32'h13);
        chk({tag, ".pc"}, if_pc, 32'h100);
        chk({tag, ".pc_added"}, if_pc_added, 32'h104);
        chk({tag, ".mis"}, 32'(fetch_misalign), 32'h0);
    endtask

    vec_t tv[$];

    initial begin
        // rv rpc gnt rvld rdata rdy | req addr valid inst pc mis
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h13, 32'h100, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h100, 0, 32'h13, 32'h100, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'hAAAA0001, 0,
                        0, 32'h100, 1, 32'hAAAA0001, 32'h100, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h104, 0, 32'hAAAA0001, 32'h100, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h104, 0, 32'hAAAA0001, 32'h100, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h2, 0, 0, 32'h104, 1, 32'h2, 32'h104, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h108, 0, 32'h2, 32'h104, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h108, 0, 32'h2, 32'h104, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h3, 0, 0, 32'h108, 1, 32'h3, 32'h108, 0));
        // five stall cycles in HOLD, one with a stray rvalid
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h108, 1, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'hBAD, 0, 0, 32'h108, 1, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h108, 1, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h108, 1, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h108, 1, 32'h3, 32'h108, 0));
        // redirect with ready in HOLD
        tv.push_back(mk(1, 32'h40, 0, 0, 0, 1, 1, 32'h40, 0, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h40, 0, 32'h3, 32'h108, 0));
        // redirect in WAIT kills the pending response
        tv.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 32'h200, 0, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'hDEADBEEF, 0,
                        1, 32'h200, 0, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h200, 0, 32'h3, 32'h108, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h4, 0, 0, 32'h200, 1, 32'h4, 32'h200, 0));
        // misaligned redirect together with ready
        tv.push_back(mk(1, 32'h302, 0, 0, 0, 1,
                        1, MIS_ADDR, 0, 32'h4, 32'h200, MIS_FLAG));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, MIS_ADDR, 0, 32'h4, 32'h200, 0));
        // redirect on the grant cycle
        tv.push_back(mk(1, 32'h500, 1, 0, 0, 0, 0, 32'h500, 0, 32'h4, 32'h200, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h5, 0, 1, 32'h500, 0, 32'h4, 32'h200, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h500, 0, 32'h4, 32'h200, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h6, 0, 0, 32'h500, 1, 32'h6, 32'h500, 0));
        // redirect in HOLD without ready drops the instruction
        tv.push_back(mk(1, 32'h600, 0, 0, 0, 0, 1, 32'h600, 0, 32'h6, 32'h500, 0));
        tv.push_back(mk(1, 32'h700, 0, 0, 0, 0, 1, 32'h700, 0, 32'h6, 32'h500, 0));
        // PC wraparound
        tv.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0,
                        1, 32'hFFFFFFFC, 0, 32'h6, 32'h500, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 32'h6, 32'h500, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h7, 0,
                        0, 32'hFFFFFFFC, 1, 32'h7, 32'hFFFFFFFC, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h7, 32'hFFFFFFFC, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h7, 32'hFFFFFFFC, 0));

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            redirect_valid = tv[i].rv;
            redirect_pc    = tv[i].rpc;
            imem_gnt       = tv[i].gnt;
            imem_rvalid    = tv[i].rvld;
            imem_rdata     = tv[i].rdata;
            if_ready       = tv[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.req", i), 32'(imem_req), 32'(tv[i].e_req));
            chk($sformatf("v%0d.addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d.valid", i), 32'(if_valid), 32'(tv[i].e_valid));
            chk($sformatf("v%0d.inst", i), if_inst, tv[i].e_inst);
            chk($sformatf("v%0d.pc", i), if_pc, tv[i].e_pc);
            chk($sformatf("v%0d.pc_added", i), if_pc_added,
                tv[i].e_pc + 32'd4);
            chk($sformatf("v%0d.mis", i), 32'(fetch_misalign),
                32'(tv[i].e_mis));
        end

        // asynchronous reset while in WAIT, late rvalid afterwards
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADBAD00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_boot.req", 32'(imem_req), 32'h1);
        chk("rst_boot.addr", imem_addr, 32'h100);
        chk("rst_boot.valid", 32'(if_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_req.valid", 32'(if_valid), 32'h0);
        chk("rst_req.inst", if_inst, 32'h13);
        chk("rst_req.req", 32'(imem_req), 32'h1);
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_gnt.req", 32'(imem_req), 32'h0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0093;
        @(posedge clk);
        #1;
        chk("rst_resp.valid", 32'(if_valid), 32'h1);
        chk("rst_resp.inst", if_inst, 32'h93);
        chk("rst_resp.pc", if_pc, 32'h100);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
